// File: rtl/row_packer_if.sv
// Beat-in / row-out handshake bundle for the row packer.
// The slave modport is the packer's view. The master modport is the view of whatever drives it.
interface row_packer_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int LANES = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [0:LANES-1][WIDTH-1:0] s_data;
    logic                        s_valid;
    logic                        s_last;
    logic                        s_ready;
    logic [0:DEPTH-1][WIDTH-1:0] m_data;
    logic                        m_valid;
    logic [CW-1:0]               m_count;
    logic                        m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_count
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_count
    );
endinterface

// File: rtl/row_packer.sv
// Packs LANES-word beats into DEPTH-word rows using two ping-pong row buffers.
// A buffer is cleared as it is released, so an early-closed row reads zero past its last beat.
module row_packer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int LANES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    row_packer_if.slave   bus
);
    localparam int BEATS     = DEPTH / LANES;
    localparam int BEAT_BITS = $clog2(BEATS) + 1;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int AW        = $clog2(DEPTH);

    logic [0:DEPTH-1][WIDTH-1:0] r_buf [0:1];
    logic [1:0]                  r_full;
    logic [CW-1:0]               r_cnt [0:1];
    logic                        r_wr_sel;
    logic                        r_rd_sel;
    logic [BEAT_BITS-1:0]        r_beat_idx;

    logic w_s_fire;
    logic w_m_fire;
    logic w_close;

    assign bus.s_ready = !r_full[r_wr_sel];
    assign bus.m_valid = r_full[r_rd_sel];
    assign bus.m_data  = r_buf[r_rd_sel];
    assign bus.m_count = r_cnt[r_rd_sel];

    assign w_s_fire = bus.s_valid & !r_full[r_wr_sel];
    assign w_m_fire = r_full[r_rd_sel] & bus.m_ready;
    assign w_close  = (r_beat_idx == BEAT_BITS'(BEATS - 1)) || bus.s_last;

    // A write needs its buffer empty and a read needs its buffer full.
    // So in any one cycle the release and the write always hit different buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_buf[b] <= '0;
                r_cnt[b] <= '0;
            end
            r_full     <= '0;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_beat_idx <= '0;
        end else begin
            if (w_m_fire) begin
                r_full[r_rd_sel] <= 1'b0;
                r_buf[r_rd_sel]  <= '0;
                r_cnt[r_rd_sel]  <= '0;
                r_rd_sel         <= ~r_rd_sel;
            end
            if (w_s_fire) begin
                for (int k = 0; k < LANES; k++) begin
                    r_buf[r_wr_sel][AW'(int'(r_beat_idx) * LANES + k)] <= bus.s_data[k];
                end
                if (w_close) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_cnt[r_wr_sel]  <= CW'((int'(r_beat_idx) + 1) * LANES);
                    r_wr_sel         <= ~r_wr_sel;
                    r_beat_idx       <= '0;
                end else begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_row_packer.sv
// Randomised and directed bench for row_packer.
// Expected rows are built from accepted beats and queued; a negedge monitor checks them.
module tb_row_packer;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 64;
    localparam int LANES  = 4;
    localparam int BEATS  = DEPTH / LANES;
    localparam int BUDGET = 5000;

    typedef logic [0:DEPTH-1][WIDTH-1:0] row_t;
    typedef logic [0:LANES-1][WIDTH-1:0] beat_t;
    typedef struct {
        row_t data;
        int   count;
    } exp_t;

    logic clk;
    logic rst_n;
    row_packer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) bus ();

    row_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    row_t part;
    int   part_words;
    bit   rand_mr;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_row(input string name, input row_t got, input row_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            for (int i = 0; i < DEPTH; i++) begin
                if (got[i] !== exp[i]) begin
                    $display("FAIL %s: word %0d got %h expected %h at %0t",
                             name, i, got[i], exp[i], $time);
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        part       = '0;
        part_words = 0;
    endtask

    // Compare the registered view first, then fold in the transfers that the next edge will take.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("s_ready", int'(bus.s_ready), int'(exp_q.size() < 2));
            chk("m_valid", int'(bus.m_valid), int'(exp_q.size() > 0));
            if (bus.m_valid && exp_q.size() > 0) begin
                chk_row("m_data", bus.m_data, exp_q[0].data);
                chk("m_count", int'(bus.m_count), exp_q[0].count);
                if (bus.m_ready) void'(exp_q.pop_front());
            end
            if (bus.s_valid && bus.s_ready) begin
                for (int k = 0; k < LANES; k++) part[part_words + k] = bus.s_data[k];
                part_words += LANES;
                if (bus.s_last || part_words == DEPTH) begin
                    exp_q.push_back('{data: part, count: part_words});
                    part       = '0;
                    part_words = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mr) bus.m_ready = ($urandom_range(0, 99) < 60);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t d, input logic last);
        int n;
        n = 0;
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_ready && n < BUDGET);
        if (!bus.s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_timeout: s_ready stuck at 0 for %0d cycles", n);
        end
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_seq_row(input int nbeats, input int first, input bit last_on_final);
        beat_t d;
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < LANES; k++) d[k] = WIDTH'(first + b * LANES + k);
            send_beat(d, last_on_final && (b == nbeats - 1));
        end
    endtask

    task automatic send_rand_row(input int max_gap);
        beat_t d;
        bit    last;
        for (int b = 0; b < BEATS; b++) begin
            repeat ($urandom_range(0, max_gap)) tick();
            for (int k = 0; k < LANES; k++) d[k] = WIDTH'($urandom);
            last = ($urandom_range(0, 7) == 0);
            send_beat(d, last);
            if (last) break;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < BUDGET) begin
            tick();
            n++;
        end
        chk("drain_rows_left", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        row_t zero_row;
        zero_row = '0;
        chk({tag, "_m_valid"}, int'(bus.m_valid), 0);
        chk({tag, "_m_count"}, int'(bus.m_count), 0);
        chk({tag, "_s_ready"}, int'(bus.s_ready), 1);
        chk_row({tag, "_m_data"}, bus.m_data, zero_row);
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs(tag);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        row_t ramp;
        row_t short_row;
        rand_mr     = 1'b0;
        rst_n       = 1'b0;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("rst_initial");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_reset_outputs("rst_release");

        // Full ramp row: visible on the edge that accepts beat 16.
        bus.m_ready = 1'b1;
        send_seq_row(BEATS, 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) ramp[i] = WIDTH'(i);
        chk("ramp_m_valid", int'(bus.m_valid), 1);
        chk("ramp_m_count", int'(bus.m_count), DEPTH);
        chk_row("ramp_m_data", bus.m_data, ramp);
        drain();

        // Early close on beat 3.
        send_seq_row(3, 1, 1'b1);
        short_row = '0;
        for (int i = 0; i < 12; i++) short_row[i] = WIDTH'(i + 1);
        chk("short_m_count", int'(bus.m_count), 12);
        chk_row("short_m_data", bus.m_data, short_row);
        send_rand_row(0);
        drain();

        // Two rows held blocks input; the third row follows once released.
        bus.m_ready = 1'b0;
        send_seq_row(BEATS, 100, 1'b0);
        send_seq_row(BEATS, 200, 1'b0);
        chk("hold2_s_ready", int'(bus.s_ready), 0);
        repeat (5) tick();
        for (int i = 0; i < DEPTH; i++) ramp[i] = WIDTH'(100 + i);
        chk_row("hold2_row_a", bus.m_data, ramp);
        bus.m_ready = 1'b1;
        send_seq_row(BEATS, 300, 1'b0);
        drain();

        // Random traffic with downstream backpressure.
        rand_mr = 1'b1;
        for (int r = 0; r < 1000; r++) send_rand_row(1);
        rand_mr     = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        drain();

        // Reset mid-row, then confirm the next row packs from word 0.
        send_seq_row(7, 500, 1'b0);
        pulse_reset("rst_mid_row");
        send_seq_row(2, 600, 1'b1);
        drain();

        // Reset with both buffers held.
        bus.m_ready = 1'b0;
        send_seq_row(BEATS, 700, 1'b0);
        send_seq_row(BEATS, 800, 1'b0);
        chk("hold2b_s_ready", int'(bus.s_ready), 0);
        pulse_reset("rst_two_held");
        bus.m_ready = 1'b1;
        send_seq_row(5, 900, 1'b1);
        drain();

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
